// File: rtl/riscv_v_wb_stage_if.sv
// riscv_v_wb_stage_if
//   Bundle of every non-clock signal on the vector writeback stage.
//   slave  : seen by riscv_v_wb_stage (consumes ALU/LSU results, drives RF write port).
//   master : seen by whatever drives the stage (producers plus RF observer).
//   Groups: alu_* / lsu_* valid-ready result channels, mask (v0 bytes),
//           rf_wr_* register-file write port, pend_vec hazard vector, idle.
interface riscv_v_wb_stage_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 128
);
  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_addr;
  logic [DATA_WIDTH-1:0] alu_data;
  logic [NUM_BYTES-1:0]  alu_byte_en;
  logic                  alu_vm;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic [NUM_BYTES-1:0]  lsu_byte_en;
  logic                  lsu_vm;

  logic [NUM_BYTES-1:0]  mask;

  logic [ADDR_WIDTH-1:0] rf_wr_addr;
  logic [NUM_BYTES-1:0]  rf_wr_en;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic [31:0]           pend_vec;
  logic                  idle;

  modport slave (
    input  alu_valid, alu_addr, alu_data, alu_byte_en, alu_vm,
    input  lsu_valid, lsu_addr, lsu_data, lsu_byte_en, lsu_vm,
    input  mask,
    output alu_ready, lsu_ready,
    output rf_wr_addr, rf_wr_en, rf_wr_data, pend_vec, idle
  );

  modport master (
    output alu_valid, alu_addr, alu_data, alu_byte_en, alu_vm,
    output lsu_valid, lsu_addr, lsu_data, lsu_byte_en, lsu_vm,
    output mask,
    input  alu_ready, lsu_ready,
    input  rf_wr_addr, rf_wr_en, rf_wr_data, pend_vec, idle
  );
endinterface

// File: rtl/riscv_v_wb_stage.sv
// riscv_v_wb_stage
//   Vector writeback stage in front of the vector register file write port.
//   ALU and LSU results are each buffered in a FIFO_DEPTH-entry FIFO with the
//   v0 mask folded into the byte enables at accept time. One FIFO head per
//   cycle is written to the RF; pend_vec flags every vreg with a buffered write.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   wb    - riscv_v_wb_stage_if.slave (alu_*/lsu_* channels, mask, rf_wr_*,
//           pend_vec, idle)
// Build option:
//   RISCV_V_WB_RR_EN - round-robin ALU/LSU arbitration; undefined gives fixed
//                      LSU-over-ALU priority.
module riscv_v_wb_stage #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 128
) (
  input logic               clk,
  input logic               rst_n,
  riscv_v_wb_stage_if.slave wb
);
  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned ALU       = 0;
  localparam int unsigned LSU       = 1;

  logic [ADDR_WIDTH-1:0] addr_q [2][FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [2][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [2][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_d [2][FIFO_DEPTH];
  logic [NUM_BYTES-1:0]  en_q   [2][FIFO_DEPTH];
  logic [NUM_BYTES-1:0]  en_d   [2][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q [2];
  logic [PTR_W-1:0]      wr_ptr_d [2];
  logic [PTR_W-1:0]      rd_ptr_q [2];
  logic [PTR_W-1:0]      rd_ptr_d [2];
  logic [CNT_W-1:0]      cnt_q [2];
  logic [CNT_W-1:0]      cnt_d [2];

  logic [1:0]            full, empty, rdy, push, pop;
  logic [ADDR_WIDTH-1:0] in_addr [2];
  logic [DATA_WIDTH-1:0] in_data [2];
  logic [NUM_BYTES-1:0]  in_en   [2];

`ifdef RISCV_V_WB_RR_EN
  localparam logic PRI_LSU = 1'b0;
  localparam logic PRI_ALU = 1'b1;
  logic pri_q, pri_d;
`endif

  // Input capture; the mask only matters for masked (vm = 0) ops.
  always_comb begin
    in_addr[ALU] = wb.alu_addr;
    in_data[ALU] = wb.alu_data;
    in_en[ALU]   = wb.alu_byte_en & ({NUM_BYTES{wb.alu_vm}} | wb.mask);
    in_addr[LSU] = wb.lsu_addr;
    in_data[LSU] = wb.lsu_data;
    in_en[LSU]   = wb.lsu_byte_en & ({NUM_BYTES{wb.lsu_vm}} | wb.mask);
    for (int unsigned s = 0; s < 2; s++) begin
      full[s]  = (cnt_q[s] == CNT_W'(FIFO_DEPTH));
      empty[s] = (cnt_q[s] == '0);
      rdy[s]   = rst_n && !full[s];
    end
    push[ALU] = wb.alu_valid && rdy[ALU];
    push[LSU] = wb.lsu_valid && rdy[LSU];
    wb.alu_ready = rdy[ALU];
    wb.lsu_ready = rdy[LSU];
  end

  // Arbiter: grants depend only on registered FIFO state (and rst_n, which
  // blocks any write in the reset cycle so discarded entries never commit).
  always_comb begin
    pop = '0;
`ifdef RISCV_V_WB_RR_EN
    pri_d = pri_q;
    if (rst_n) begin
      if (!empty[LSU] && (empty[ALU] || pri_q == PRI_LSU)) pop[LSU] = 1'b1;
      else if (!empty[ALU])                                pop[ALU] = 1'b1;
    end
    if (pop[LSU])      pri_d = PRI_ALU;
    else if (pop[ALU]) pri_d = PRI_LSU;
`else
    if (rst_n) begin
      if (!empty[LSU])      pop[LSU] = 1'b1;
      else if (!empty[ALU]) pop[ALU] = 1'b1;
    end
`endif
  end

  // FIFO next state
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    en_d   = en_q;
    for (int unsigned s = 0; s < 2; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s];
      rd_ptr_d[s] = rd_ptr_q[s];
      cnt_d[s]    = cnt_q[s];
      if (push[s]) begin
        addr_d[s][wr_ptr_q[s]] = in_addr[s];
        data_d[s][wr_ptr_q[s]] = in_data[s];
        en_d[s][wr_ptr_q[s]]   = in_en[s];
        wr_ptr_d[s]            = wr_ptr_q[s] + PTR_W'(1);
      end
      if (pop[s]) rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
      case ({push[s], pop[s]})
        2'b10:   cnt_d[s] = cnt_q[s] + CNT_W'(1);
        2'b01:   cnt_d[s] = cnt_q[s] - CNT_W'(1);
        default: cnt_d[s] = cnt_q[s];
      endcase
    end
  end

  // RF write port, hazard vector and idle
  always_comb begin
    wb.rf_wr_addr = '0;
    wb.rf_wr_en   = '0;
    wb.rf_wr_data = '0;
    if (pop[LSU]) begin
      wb.rf_wr_addr = addr_q[LSU][rd_ptr_q[LSU]];
      wb.rf_wr_en   = en_q[LSU][rd_ptr_q[LSU]];
      wb.rf_wr_data = data_q[LSU][rd_ptr_q[LSU]];
    end else if (pop[ALU]) begin
      wb.rf_wr_addr = addr_q[ALU][rd_ptr_q[ALU]];
      wb.rf_wr_en   = en_q[ALU][rd_ptr_q[ALU]];
      wb.rf_wr_data = data_q[ALU][rd_ptr_q[ALU]];
    end
    wb.pend_vec = '0;
    if (rst_n) begin
      for (int unsigned s = 0; s < 2; s++) begin
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
          // Live entries are the cnt_q slots starting at the read pointer.
          if (CNT_W'(i) < cnt_q[s])
            wb.pend_vec[addr_q[s][rd_ptr_q[s] + PTR_W'(i)]] = 1'b1;
        end
      end
    end
    wb.idle = !rst_n || (empty == 2'b11);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '{default: '0};
      wr_ptr_q <= '{default: '0};
      rd_ptr_q <= '{default: '0};
`ifdef RISCV_V_WB_RR_EN
      pri_q    <= PRI_LSU;
`endif
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef RISCV_V_WB_RR_EN
      pri_q    <= pri_d;
`endif
    end
  end

  // Entry payload needs no reset: it is only observed through cnt_q.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    en_q   <= en_d;
  end
endmodule
